// File: rtl/alu_seq_pkg.sv
// Shared definitions for the 64-bit add/subtract sequencer that drives the
// 32-bit ALU: operation encodings, ALU function selects, flag bit positions,
// FSM states and small helper functions.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBC = 2'b11
  } op_e;

  localparam logic [4:0] FUNSEL_PASS_A_32 = 5'b10000;
  localparam logic [4:0] FUNSEL_ADDC_32   = 5'b10101;

  localparam int ZERO     = 3;
  localparam int CARRY    = 2;
  localparam int NEGATIVE = 1;
  localparam int OVERFLOW = 0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE_LO = 3'd1,
    ST_WAIT_LO  = 3'd2,
    ST_ISSUE_HI = 3'd3,
    ST_WAIT_HI  = 3'd4,
    ST_RESP     = 3'd5
  } state_e;

  // Subtracting forms feed the ALU the one's complement of B.
  function automatic logic op_inverts_b(input logic [1:0] op);
    logic inv;
    case (op)
      OP_ADD:  inv = 1'b0;
      OP_SUB:  inv = 1'b1;
      OP_ADC:  inv = 1'b0;
      OP_SBC:  inv = 1'b1;
      default: inv = 1'b0;
    endcase
    return inv;
  endfunction

  // Carry-in for the low word: SUB supplies the +1 of two's complement,
  // ADC/SBC take the caller's carry (SBC: 1 means no borrow).
  function automatic logic op_cin0(input logic [1:0] op, input logic cin);
    logic c;
    case (op)
      OP_ADD:  c = 1'b0;
      OP_SUB:  c = 1'b1;
      OP_ADC:  c = cin;
      OP_SBC:  c = cin;
      default: c = 1'b0;
    endcase
    return c;
  endfunction

  // {Z,C,N,V} of a 64-bit sum; V uses the operand actually fed to the ALU.
  function automatic logic [3:0] flags64(input logic [63:0] res,
                                         input logic        carry,
                                         input logic        a_msb,
                                         input logic        b_msb);
    logic [3:0] f;
    f[ZERO]     = (res == 64'd0);
    f[CARRY]    = carry;
    f[NEGATIVE] = res[63];
    f[OVERFLOW] = (a_msb == b_msb) && (res[63] != a_msb);
    return f;
  endfunction

endpackage

// File: rtl/alu_wide_sequencer.sv
// 64-bit add/subtract sequencer in front of a 32-bit ALU. Each accepted
// request is issued as a low-word then a high-word ALU operation with the
// carry chained between them, and the 64-bit result plus ZCNV is returned.
// Optional build macro ALU_WIDE_SELFCHECK_EN adds rsp_mismatch, which flags
// a disagreement between the ALU-produced result/carry and a native 65-bit sum.
module alu_wide_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned ALU_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  input  logic        req_cin,
  output logic [4:0]  alu_funsel,
  output logic [31:0] alu_in_a,
  output logic [31:0] alu_in_b,
  output logic        alu_cin,
  input  logic [31:0] alu_out,
  input  logic [3:0]  alu_flags,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_result,
  output logic [3:0]  rsp_flags
`ifdef ALU_WIDE_SELFCHECK_EN
  ,
  output logic        rsp_mismatch
`endif
);

  // Final wait-counter value; ALU_LATENCY is legal from 1 to 7.
  localparam logic [2:0] LAST_CNT = 3'(ALU_LATENCY - 1);

  state_e      state_r;
  state_e      state_nx_s;
  logic [2:0]  cnt_r;
  logic        wait_done_s;
  logic        accept_s;
  logic [63:0] a_r;
  logic [63:0] b_eff_r;
  logic [31:0] res_lo_r;
  logic [63:0] b_eff_s;
  logic        cin0_s;
  logic        unused_flags_s;

`ifdef ALU_WIDE_SELFCHECK_EN
  logic [64:0] exp_r;
`endif

  assign accept_s    = req_valid && (state_r == ST_IDLE);
  assign wait_done_s = (cnt_r == LAST_CNT);
  assign b_eff_s     = op_inverts_b(req_op) ? ~req_b : req_b;
  assign cin0_s      = op_cin0(req_op, req_cin);

  // Only the ALU carry is consumed; Z/N/V are recomputed over 64 bits.
  assign unused_flags_s = ^{alu_flags[ZERO], alu_flags[NEGATIVE], alu_flags[OVERFLOW]};

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode for the issue/wait/respond sequence.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nx_s = ST_ISSUE_LO;
        else          state_nx_s = ST_IDLE;
      end
      ST_ISSUE_LO: state_nx_s = ST_WAIT_LO;
      ST_WAIT_LO: begin
        if (wait_done_s) state_nx_s = ST_ISSUE_HI;
        else             state_nx_s = ST_WAIT_LO;
      end
      ST_ISSUE_HI: state_nx_s = ST_WAIT_HI;
      ST_WAIT_HI: begin
        if (wait_done_s) state_nx_s = ST_RESP;
        else             state_nx_s = ST_WAIT_HI;
      end
      ST_RESP: begin
        if (rsp_ready) state_nx_s = ST_IDLE;
        else           state_nx_s = ST_RESP;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Counts ALU latency cycles inside each wait state; zero everywhere else.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_r <= 3'd0;
    end else if (((state_r == ST_WAIT_LO) || (state_r == ST_WAIT_HI)) && !wait_done_s) begin
      cnt_r <= cnt_r + 3'd1;
    end else begin
      cnt_r <= 3'd0;
    end
  end

  // Operand capture, ALU drive (loaded one edge ahead so inputs are stable
  // for the whole issue+wait window) and response formation.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      req_ready  <= 1'b1;
      a_r        <= 64'd0;
      b_eff_r    <= 64'd0;
      res_lo_r   <= 32'd0;
      alu_funsel <= FUNSEL_PASS_A_32;
      alu_in_a   <= 32'd0;
      alu_in_b   <= 32'd0;
      alu_cin    <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_result <= 64'd0;
      rsp_flags  <= 4'd0;
`ifdef ALU_WIDE_SELFCHECK_EN
      exp_r        <= 65'd0;
      rsp_mismatch <= 1'b0;
`endif
    end else begin
      req_ready <= (state_nx_s == ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            a_r        <= req_a;
            b_eff_r    <= b_eff_s;
            alu_funsel <= FUNSEL_ADDC_32;
            alu_in_a   <= req_a[31:0];
            alu_in_b   <= b_eff_s[31:0];
            alu_cin    <= cin0_s;
`ifdef ALU_WIDE_SELFCHECK_EN
            exp_r <= {1'b0, req_a} + {1'b0, b_eff_s} + {64'd0, cin0_s};
`endif
          end
        end
        ST_WAIT_LO: begin
          if (wait_done_s) begin
            // Low-word carry goes straight onto alu_cin for the high word.
            res_lo_r <= alu_out;
            alu_in_a <= a_r[63:32];
            alu_in_b <= b_eff_r[63:32];
            alu_cin  <= alu_flags[CARRY];
          end
        end
        ST_WAIT_HI: begin
          if (wait_done_s) begin
            rsp_valid  <= 1'b1;
            rsp_result <= {alu_out, res_lo_r};
            rsp_flags  <= flags64({alu_out, res_lo_r}, alu_flags[CARRY],
                                  a_r[63], b_eff_r[63]);
`ifdef ALU_WIDE_SELFCHECK_EN
            rsp_mismatch <= ({alu_flags[CARRY], alu_out, res_lo_r} != exp_r);
`endif
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
`ifdef ALU_WIDE_SELFCHECK_EN
            rsp_mismatch <= 1'b0;
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// Directed bench for alu_wide_sequencer: two instances (ALU_LATENCY 1 and 3)
// each paired with a behavioural pipelined 32-bit ALU.
module tb_alu_wide_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [1:0]  req_op;
  logic [63:0] req_a, req_b;
  logic        req_cin;

  logic        req_valid1, req_ready1, rsp_valid1, rsp_ready1, cin1;
  logic [4:0]  funsel1;
  logic [31:0] in_a1, in_b1, out1;
  logic [3:0]  aflags1, rflags1;
  logic [63:0] result1;

  logic        req_valid3, req_ready3, rsp_valid3, rsp_ready3, cin3;
  logic [4:0]  funsel3;
  logic [31:0] in_a3, in_b3, out3;
  logic [3:0]  aflags3, rflags3;
  logic [63:0] result3;

`ifdef ALU_WIDE_SELFCHECK_EN
  logic mm1, mm3;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  alu_wide_sequencer #(.ALU_LATENCY(1)) u_dut1 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .alu_funsel(funsel1), .alu_in_a(in_a1), .alu_in_b(in_b1), .alu_cin(cin1),
    .alu_out(out1), .alu_flags(aflags1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
    .rsp_result(result1), .rsp_flags(rflags1)
`ifdef ALU_WIDE_SELFCHECK_EN
    , .rsp_mismatch(mm1)
`endif
  );

  alu_wide_sequencer #(.ALU_LATENCY(3)) u_dut3 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .alu_funsel(funsel3), .alu_in_a(in_a3), .alu_in_b(in_b3), .alu_cin(cin3),
    .alu_out(out3), .alu_flags(aflags3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
    .rsp_result(result3), .rsp_flags(rflags3)
`ifdef ALU_WIDE_SELFCHECK_EN
    , .rsp_mismatch(mm3)
`endif
  );

  // Behavioural 32-bit ALU: returns {Z,C,N,V, out}.
  function automatic logic [35:0] alu_model(input logic [4:0] fs, input logic [31:0] a,
                                            input logic [31:0] b, input logic c);
    logic [32:0] s;
    logic [31:0] o;
    logic        co, v;
    if (fs == 5'b10101) begin
      s  = {1'b0, a} + {1'b0, b} + {32'd0, c};
      o  = s[31:0];
      co = s[32];
      v  = (a[31] == b[31]) && (o[31] != a[31]);
    end else begin
      o  = a;
      co = 1'b0;
      v  = 1'b0;
    end
    return {(o == 32'd0), co, o[31], v, o};
  endfunction

  logic [35:0] p1;
  logic [35:0] p3 [0:2];

  // One-stage ALU pipeline for the latency-1 instance.
  always @(posedge clock) p1 <= alu_model(funsel1, in_a1, in_b1, cin1);

  // Three-stage ALU pipeline for the latency-3 instance.
  always @(posedge clock) begin
    p3[0] <= alu_model(funsel3, in_a3, in_b3, cin3);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  assign out1    = p1[31:0];
  assign aflags1 = p1[35:32];
  assign out3    = p3[2][31:0];
  assign aflags3 = p3[2][35:32];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full transaction on the latency-1 instance with rsp_ready held high.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic cin, input logic [31:0] lo_b,
                        input logic lo_cin, input logic [63:0] res, input logic [3:0] fl);
    int n;
    @(negedge clock);
    req_op = op; req_a = a; req_b = b; req_cin = cin; req_valid1 = 1'b1;
    check({tag, ".rdy"}, 64'(req_ready1), 64'd1);
    @(posedge clock); #1;
    req_valid1 = 1'b0;
    check({tag, ".fs_lo"},  64'(funsel1), 64'h15);
    check({tag, ".ina_lo"}, 64'(in_a1), 64'(a[31:0]));
    check({tag, ".inb_lo"}, 64'(in_b1), 64'(lo_b));
    check({tag, ".cin_lo"}, 64'(cin1), 64'(lo_cin));
    n = 0;
    while (!rsp_valid1 && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    check({tag, ".lat"},    64'(n), 64'd4);
    check({tag, ".result"}, result1, res);
    check({tag, ".flags"},  64'(rflags1), 64'(fl));
    check({tag, ".busy"},   64'(req_ready1), 64'd0);
    @(posedge clock); #1;
    check({tag, ".drop"},   64'(rsp_valid1), 64'd0);
    check({tag, ".idle"},   64'(req_ready1), 64'd1);
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    req_valid1 = 1'b0; req_valid3 = 1'b0;
    rsp_ready1 = 1'b1; rsp_ready3 = 1'b1;
    req_op = 2'b00; req_a = 64'd0; req_b = 64'd0; req_cin = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst.rsp_valid", 64'(rsp_valid1), 64'd0);
    check("rst.result",    result1, 64'd0);
    check("rst.flags",     64'(rflags1), 64'd0);
    check("rst.funsel",    64'(funsel1), 64'h10);
    check("rst.in_a",      64'(in_a1), 64'd0);
    check("rst.in_b",      64'(in_b1), 64'd0);
    check("rst.cin",       64'(cin1), 64'd0);
    check("rst.req_ready", 64'(req_ready1), 64'd1);
    check("rst.ready3",    64'(req_ready3), 64'd1);
    @(negedge clock);
    reset_n = 1'b1;

    run_op("add_carry",  2'b00, 64'h00000000_FFFFFFFF, 64'd1, 1'b0, 32'h00000001, 1'b0,
           64'h00000001_00000000, 4'b0000);
    run_op("sub_borrow", 2'b01, 64'd0, 64'd1, 1'b0, 32'hFFFFFFFE, 1'b1,
           64'hFFFFFFFF_FFFFFFFF, 4'b0010);
    run_op("add_ovf",    2'b00, 64'h7FFFFFFF_FFFFFFFF, 64'd1, 1'b0, 32'h00000001, 1'b0,
           64'h80000000_00000000, 4'b0011);
    run_op("adc_wrap",   2'b10, 64'hFFFFFFFF_FFFFFFFF, 64'd0, 1'b1, 32'h00000000, 1'b1,
           64'd0, 4'b1100);
    run_op("sbc_c0",     2'b11, 64'd5, 64'd5, 1'b0, 32'hFFFFFFFA, 1'b0,
           64'hFFFFFFFF_FFFFFFFF, 4'b0010);
    run_op("sbc_c1",     2'b11, 64'd5, 64'd5, 1'b1, 32'hFFFFFFFA, 1'b1,
           64'd0, 4'b1100);

    // Backpressure: response held for 3 cycles, second request waits.
    rsp_ready1 = 1'b0;
    @(negedge clock);
    req_op = 2'b00; req_a = 64'd1; req_b = 64'd2; req_cin = 1'b0; req_valid1 = 1'b1;
    @(posedge clock); #1;
    req_valid1 = 1'b0;
    n = 0;
    while (!rsp_valid1 && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    check("bp.lat", 64'(n), 64'd4);
    @(negedge clock);
    req_a = 64'd10; req_b = 64'd20; req_valid1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      check("bp.hold_result", result1, 64'd3);
      check("bp.hold_flags",  64'(rflags1), 64'd0);
      check("bp.hold_valid",  64'(rsp_valid1), 64'd1);
      check("bp.hold_busy",   64'(req_ready1), 64'd0);
    end
    @(negedge clock);
    rsp_ready1 = 1'b1;
    @(posedge clock); #1;
    check("bp.hs_valid",  64'(rsp_valid1), 64'd0);
    check("bp.hs_ready",  64'(req_ready1), 64'd1);
    check("bp.not_taken", 64'(in_a1), 64'd0);
    @(posedge clock); #1;
    req_valid1 = 1'b0;
    check("bp.taken_busy", 64'(req_ready1), 64'd0);
    check("bp.taken_ina",  64'(in_a1), 64'd10);
    n = 0;
    while (!rsp_valid1 && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    check("bp2.lat",    64'(n), 64'd4);
    check("bp2.result", result1, 64'd30);
    @(posedge clock); #1;

    // Reset during WAIT_HI drops the request.
    @(negedge clock);
    req_a = 64'd1; req_b = 64'd2; req_op = 2'b00; req_valid1 = 1'b1;
    @(posedge clock); #1;
    req_valid1 = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    @(posedge clock); #1;
    check("mid_rst.valid",  64'(rsp_valid1), 64'd0);
    check("mid_rst.ready",  64'(req_ready1), 64'd1);
    check("mid_rst.funsel", 64'(funsel1), 64'h10);
    check("mid_rst.result", result1, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    check("mid_rst.no_rsp", 64'(rsp_valid1), 64'd0);
    check("mid_rst.idle",   64'(req_ready1), 64'd1);

    // Latency-3 instance: 8-cycle response, ALU inputs stable through waits.
    @(negedge clock);
    req_op = 2'b00; req_a = 64'h00000000_FFFFFFFF; req_b = 64'd1; req_cin = 1'b0;
    req_valid3 = 1'b1;
    check("l3.rdy", 64'(req_ready3), 64'd1);
    @(posedge clock); #1;
    req_valid3 = 1'b0;
    n = 0;
    while (!rsp_valid3 && n < 30) begin
      if (n < 4) begin
        check("l3.lo_ina", 64'(in_a3), 64'hFFFFFFFF);
        check("l3.lo_inb", 64'(in_b3), 64'd1);
        check("l3.lo_cin", 64'(cin3), 64'd0);
      end else begin
        check("l3.hi_ina", 64'(in_a3), 64'd0);
        check("l3.hi_inb", 64'(in_b3), 64'd0);
        check("l3.hi_cin", 64'(cin3), 64'd1);
      end
      @(posedge clock); #1;
      n++;
    end
    check("l3.lat",    64'(n), 64'd8);
    check("l3.result", result3, 64'h00000001_00000000);
    check("l3.flags",  64'(rflags3), 64'd0);
    @(posedge clock); #1;
    check("l3.drop",   64'(rsp_valid3), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
